// File: rtl/btn_debounce_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding and
// the default qualification counter width.
package btn_debounce_pkg;

  localparam int unsigned DEFAULT_N = 20;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PWAIT = 2'b01,
    S_HELD  = 2'b11,
    S_RWAIT = 2'b10
  } state_t;

endpackage

// File: rtl/btn_debounce_sync_ff.sv
// Multi-flop synchroniser for an asynchronous single-bit input; flops clear
// to 0 on reset so a held input is seen as a fresh 0->1 edge afterwards.
module sync_ff #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic n_rst,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/btn_debounce.sv
// Push-button debouncer: synchronised input qualified by a 2^N-cycle
// down-counter FSM, with registered level and one-cycle press/release strobes.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int unsigned N           = DEFAULT_N,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic n_rst,
  input  logic i_btn_in,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  logic         w_btn_s;
  state_t       r_state, w_state_nxt;
  logic [N-1:0] r_cnt, w_cnt_nxt;
  logic         r_level, r_press, r_release;
  logic         w_level_nxt, w_press_nxt, w_release_nxt;

  sync_ff #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .n_rst(n_rst),
    .i_d  (i_btn_in),
    .o_q  (w_btn_s)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

  // cnt is tested for zero before decrementing, so a wait lasts exactly 2^N
  // cycles and can never wrap.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_btn_s) begin
          w_state_nxt = S_PWAIT;
          w_cnt_nxt   = '1;
        end
      end
      S_PWAIT: begin
        if (!w_btn_s) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == '0) begin
          w_state_nxt = S_HELD;
          w_press_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - N'(1);
        end
      end
      S_HELD: begin
        if (!w_btn_s) begin
          w_state_nxt = S_RWAIT;
          w_cnt_nxt   = '1;
        end
      end
      S_RWAIT: begin
        if (w_btn_s) begin
          w_state_nxt = S_HELD;
        end else if (r_cnt == '0) begin
          w_state_nxt   = S_IDLE;
          w_release_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - N'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_level_nxt = (w_state_nxt == S_HELD) || (w_state_nxt == S_RWAIT);
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule
